// File: rtl/synth_env_pkg.sv
// rtl/synth_env_pkg.sv - shared envelope state encodings, default widths and full-scale level
package synth_env_pkg;

  localparam int DEF_SAMPLE_W = 32;
  localparam int DEF_LEVEL_W  = 16;
  localparam int DEF_RATE_W   = 16;

  localparam logic [DEF_LEVEL_W-1:0] LEVEL_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

endpackage

// File: rtl/env_scaler.sv
// rtl/env_scaler.sv - registered noise x level multiply keeping the upper SAMPLE_W bits
module env_scaler #(
  parameter int SAMPLE_W = 32,
  parameter int LEVEL_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_i,
  input  logic [SAMPLE_W-1:0] noise_i,
  input  logic [LEVEL_W-1:0]  level_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                valid_o
);

  localparam int PW = SAMPLE_W + LEVEL_W;

  logic [SAMPLE_W-1:0] prod_hi;
  logic [LEVEL_W-1:0]  prod_lo_unused;
  logic [SAMPLE_W-1:0] sample_q;
  logic                valid_q;

  assign {prod_hi, prod_lo_unused} = PW'(noise_i) * PW'(level_i);

  // level_i is the pre-update level, so the product reflects the state before this tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= tick_i;
      if (tick_i) begin
        sample_q <= prod_hi;
      end
    end
  end

  assign sample_o = sample_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/noise_envelope.sv
// rtl/noise_envelope.sv - ADSR envelope FSM applied to the noise sample; NOISE_ENV_EXP_RELEASE_EN selects exponential release
module noise_envelope
  import synth_env_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int LEVEL_W  = DEF_LEVEL_W,
  parameter int RATE_W   = DEF_RATE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                gate,
  input  logic [SAMPLE_W-1:0] noise_in,
  input  logic [RATE_W-1:0]   attack_rate,
  input  logic [RATE_W-1:0]   decay_rate,
  input  logic [LEVEL_W-1:0]  sustain_level,
  input  logic [RATE_W-1:0]   release_rate,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                out_valid,
  output logic [LEVEL_W-1:0]  level_out,
  output logic [2:0]          state_out,
  output logic                busy
);

  localparam int                 LW1     = LEVEL_W + 1;
  localparam logic [LEVEL_W-1:0] LVL_MAX = '1;
  localparam logic [LW1-1:0]     MAX_W   = {1'b0, LVL_MAX};

  env_state_e         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               gate_q;
  logic               busy_q;

  logic               rise, fall;
  logic [LW1-1:0]     up_sum, dec_diff, rel_diff, rel_step;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

`ifdef NOISE_ENV_EXP_RELEASE_EN
  logic unused_rel_hi;
  assign unused_rel_hi = ^release_rate[RATE_W-1:4];

  always_comb begin
    rel_step = {1'b0, level_q >> release_rate[3:0]};
    if (rel_step == '0) begin
      rel_step = LW1'(1);
    end
  end
`else
  assign rel_step = LW1'(release_rate);
`endif

  // one extra bit catches overflow/underflow so every step saturates instead of wrapping
  assign up_sum   = {1'b0, level_q} + LW1'(attack_rate);
  assign dec_diff = {1'b0, level_q} - LW1'(decay_rate);
  assign rel_diff = {1'b0, level_q} - rel_step;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (rise && (state_q == ST_IDLE || state_q == ST_RELEASE)) begin
      state_d = ST_ATTACK;
    end else if (fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                          state_q == ST_SUSTAIN)) begin
      state_d = ST_RELEASE;
    end else begin
      case (state_q)
        ST_IDLE: level_d = '0;
        ST_ATTACK: begin
          if (up_sum >= MAX_W) begin
            level_d = LVL_MAX;
            state_d = ST_DECAY;
          end else begin
            level_d = up_sum[LEVEL_W-1:0];
          end
        end
        ST_DECAY: begin
          if (dec_diff[LEVEL_W] || (dec_diff <= {1'b0, sustain_level})) begin
            level_d = sustain_level;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = dec_diff[LEVEL_W-1:0];
          end
        end
        ST_SUSTAIN: level_d = sustain_level;
        ST_RELEASE: begin
          if (rel_diff[LEVEL_W] || (rel_diff == '0)) begin
            level_d = '0;
            state_d = ST_IDLE;
          end else begin
            level_d = rel_diff[LEVEL_W-1:0];
          end
        end
        default: begin
          level_d = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (tick) begin
      state_q <= state_d;
      level_q <= level_d;
      gate_q  <= gate;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  env_scaler #(
    .SAMPLE_W (SAMPLE_W),
    .LEVEL_W  (LEVEL_W)
  ) u_scaler (
    .clk      (clk),
    .rst      (rst),
    .tick_i   (tick),
    .noise_i  (noise_in),
    .level_i  (level_q),
    .sample_o (sample_out),
    .valid_o  (out_valid)
  );

  assign level_out = level_q;
  assign state_out = state_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_noise_envelope.sv
// tb/tb_noise_envelope.sv - directed bench with an arithmetic ADSR model checked every cycle
module tb_noise_envelope;

  logic        clk = 1'b0;
  logic        rst, tick, gate;
  logic [31:0] noise_in;
  logic [15:0] attack_rate, decay_rate, sustain_level, release_rate;
  logic [31:0] sample_out;
  logic        out_valid;
  logic [15:0] level_out;
  logic [2:0]  state_out;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  int              m_state = 0;
  int              m_level = 0;
  bit              m_gate  = 0;
  longint unsigned m_sample = 0;
  bit              m_valid  = 0;

  noise_envelope dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .gate          (gate),
    .noise_in      (noise_in),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .sample_out    (sample_out),
    .out_valid     (out_valid),
    .level_out     (level_out),
    .state_out     (state_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Envelope rules in plain integer arithmetic: 0=IDLE 1=ATTACK 2=DECAY 3=SUSTAIN 4=RELEASE
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_level = 0; m_gate = 0; m_sample = 0; m_valid = 0;
    end else begin
      m_valid = tick;
      if (tick) begin
        longint unsigned n;
        bit r, f;
        int nl;
        n = noise_in;
        m_sample = (n * longint'(m_level)) >> 16;
        r = gate && !m_gate;
        f = !gate && m_gate;
        m_gate = gate;
        if (r && (m_state == 0 || m_state == 4)) m_state = 1;
        else if (f && (m_state >= 1 && m_state <= 3)) m_state = 4;
        else if (m_state == 1) begin
          nl = m_level + int'(attack_rate);
          if (nl >= 65535) begin nl = 65535; m_state = 2; end
          m_level = nl;
        end else if (m_state == 2) begin
          nl = m_level - int'(decay_rate);
          if (nl <= int'(sustain_level)) begin nl = sustain_level; m_state = 3; end
          m_level = nl;
        end else if (m_state == 3) m_level = sustain_level;
        else if (m_state == 4) begin
          nl = m_level - int'(release_rate);
          if (nl <= 0) begin nl = 0; m_state = 0; end
          m_level = nl;
        end else m_level = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_state", state_out, longint'(m_state));
    chk("cmp_level", level_out, longint'(m_level));
    chk("cmp_busy", busy, longint'(m_state != 0));
    chk("cmp_valid", out_valid, longint'(m_valid));
    chk("cmp_sample", sample_out, m_sample);
  end

  task automatic tick_once();
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  logic [15:0] att_exp [4] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
  logic [15:0] dec_exp [4] = '{16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hC000};

  initial begin
    rst = 1'b1; tick = 1'b0; gate = 1'b0; noise_in = '0;
    attack_rate = '0; decay_rate = '0; sustain_level = '0; release_rate = '0;
    repeat (3) @(negedge clk);
    chk("rst_level", level_out, 0);
    chk("rst_state", state_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sample", sample_out, 0);
    rst = 1'b0;

    noise_in = 32'hDEAD_BEEF;
    tick_once();
    chk("idle_valid_pulse", out_valid, 1);
    chk("idle_sample", sample_out, 0);
    @(negedge clk);
    chk("idle_valid_drop", out_valid, 0);
    tick_once();
    chk("idle_state", state_out, 0);

    attack_rate = 16'h4000; gate = 1'b1; noise_in = 32'hFFFF_FFFF;
    tick_once();
    chk("rise_state", state_out, 1);
    chk("rise_level", level_out, 0);
    for (int i = 0; i < 4; i++) begin
      tick_once();
      chk("attack_level", level_out, att_exp[i]);
    end
    chk("attack_to_decay", state_out, 2);

    decay_rate = 16'h1000; sustain_level = 16'hC000;
    for (int i = 0; i < 4; i++) begin
      tick_once();
      chk("decay_level", level_out, dec_exp[i]);
    end
    chk("decay_to_sustain", state_out, 3);
    sustain_level = 16'h8000;
    tick_once();
    chk("sustain_track", level_out, 16'h8000);

    tick_once();
    chk("scale_full", sample_out, 32'h7FFF_FFFF);
    repeat (4) @(negedge clk);
    chk("scale_hold", sample_out, 32'h7FFF_FFFF);

    gate = 1'b0; @(negedge clk); gate = 1'b1;
    tick_once();
    chk("glitch_ignored", state_out, 3);
    noise_in = 32'h1234_5678;
    tick_once();
    chk("scale_half", sample_out, 32'h091A_2B3C);

    release_rate = 16'h3000; gate = 1'b0;
    tick_once();
    chk("fall_state", state_out, 4);
    chk("fall_level", level_out, 16'h8000);
    tick_once();
    chk("rel_level1", level_out, 16'h5000);
    tick_once();
    chk("rel_level2", level_out, 16'h2000);
    gate = 1'b1;
    tick_once();
    chk("retrig_state", state_out, 1);
    chk("retrig_level", level_out, 16'h2000);
    tick_once();
    chk("retrig_attack", level_out, 16'h6000);
    gate = 1'b0;
    repeat (3) tick_once();
    chk("rel_to_idle", state_out, 0);
    chk("rel_idle_busy", busy, 0);

    attack_rate = 16'h0000; gate = 1'b1;
    repeat (3) tick_once();
    chk("stall_state", state_out, 1);
    chk("stall_level", level_out, 0);

    attack_rate = 16'h1000;
    tick_once();
    tick_once();
    chk("pre_abort_level", level_out, 16'h2000);
    #2 rst = 1'b1;
    #1;
    chk("abort_level", level_out, 0);
    chk("abort_state", state_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_sample", sample_out, 0);
    @(negedge clk);
    rst = 1'b0;
    tick_once();
    chk("post_abort_rise", state_out, 1);
    chk("post_abort_level", level_out, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
